// File: rtl/seg_scan_driver.sv
// Eight-anode seven-segment scan driver: rotates four BCD digits onto the
// upper anodes with dead-time, per-slot snapshot, leading-zero and global blanking.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned DEAD_CYCLES = 16,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic        sysclock,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank,
  output logic [7:0]  anode,
  output logic [7:0]  seg,
  output logic [1:0]  slot_idx,
  output logic        frame_tick
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEAD_LOAD  = DW'(DEAD_CYCLES - 1);

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_ON   = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [DW-1:0] dead_cnt;
  logic [15:0]   snap_digits;
  logic [3:0]    snap_dp;

  logic [3:0]    cur_digit;
  logic          cur_dp;
  logic          lz_dark;
  logic          lit;
  logic [6:0]    enc;
  logic [7:0]    anode_nx;
  logic [7:0]    seg_nx;

  // Select the snapshot nibble for the active slot and decide whether it is lit.
  always_comb begin
    cur_digit = 4'h0;
    cur_dp    = 1'b0;
    lz_dark   = 1'b0;
    case (slot_idx)
      2'd0: begin cur_digit = snap_digits[3:0];   cur_dp = snap_dp[0]; end
      2'd1: begin cur_digit = snap_digits[7:4];   cur_dp = snap_dp[1]; end
      2'd2: begin cur_digit = snap_digits[11:8];  cur_dp = snap_dp[2]; end
      default: begin cur_digit = snap_digits[15:12]; cur_dp = snap_dp[3]; end
    endcase
    if (LZ_BLANK) begin
      case (slot_idx)
        2'd1:    lz_dark = (snap_digits[15:4] == 12'h000);
        2'd2:    lz_dark = (snap_digits[15:8] == 8'h00);
        2'd3:    lz_dark = (snap_digits[15:12] == 4'h0);
        default: lz_dark = 1'b0;
      endcase
    end
    lit = (state == ST_ON) && !blank && !lz_dark;
  end

  // Active-low segment pattern, bits g..a; values above 9 show a dash.
  always_comb begin
    enc = 7'h3F;
    case (cur_digit)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = 7'h3F;
    endcase
  end

  always_comb begin
    anode_nx = 8'hFF;
    seg_nx   = 8'hFF;
    if (lit) begin
      anode_nx = ~(8'h10 << slot_idx);
      seg_nx   = {~cur_dp, enc};
    end
  end

  // Slot sequencer: DEAD_CYCLES dark, then SCAN_DIV lit; outputs lag state by one edge.
  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      state       <= ST_DEAD;
      dead_cnt    <= DEAD_LOAD;
      presc       <= '0;
      slot_idx    <= 2'd3;
      snap_digits <= 16'h0000;
      snap_dp     <= 4'h0;
      anode       <= 8'hFF;
      seg         <= 8'hFF;
      frame_tick  <= 1'b0;
    end else begin
      anode      <= anode_nx;
      seg        <= seg_nx;
      frame_tick <= 1'b0;
      case (state)
        ST_DEAD: begin
          if (dead_cnt == '0) begin
            state       <= ST_ON;
            presc       <= '0;
            slot_idx    <= slot_idx + 2'd1;
            snap_digits <= digits;
            snap_dp     <= dp_in;
            frame_tick  <= (slot_idx == 2'd3);
          end else begin
            dead_cnt <= dead_cnt - DW'(1);
          end
        end
        ST_ON: begin
          if (presc == PRESC_LAST) begin
            state    <= ST_DEAD;
            dead_cnt <= DEAD_LOAD;
            presc    <= '0;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        default: begin
          state    <= ST_DEAD;
          dead_cnt <= DEAD_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: two instances (leading-zero blanking on/off)
// share stimulus; per-cycle expectations are queued and popped by a monitor.
module tb_seg_scan_driver;

  localparam int unsigned S    = 8;
  localparam int unsigned D    = 2;
  localparam int unsigned SLOT = S + D;

  logic        sysclock = 1'b0;
  logic        reset    = 1'b1;
  logic [15:0] digits   = 16'h1234;
  logic [3:0]  dp_in    = 4'h0;
  logic        blank    = 1'b0;

  logic [7:0]  anode_a, seg_a, anode_b, seg_b;
  logic [1:0]  slot_a, slot_b;
  logic        ft_a, ft_b;

  seg_scan_driver #(.SCAN_DIV(S), .DEAD_CYCLES(D), .LZ_BLANK(1'b1)) dut_a (
    .sysclock(sysclock), .reset(reset), .digits(digits), .dp_in(dp_in), .blank(blank),
    .anode(anode_a), .seg(seg_a), .slot_idx(slot_a), .frame_tick(ft_a));

  seg_scan_driver #(.SCAN_DIV(S), .DEAD_CYCLES(D), .LZ_BLANK(1'b0)) dut_b (
    .sysclock(sysclock), .reset(reset), .digits(digits), .dp_in(dp_in), .blank(blank),
    .anode(anode_b), .seg(seg_b), .slot_idx(slot_b), .frame_tick(ft_b));

  always #5 sysclock = ~sysclock;

  typedef struct {
    logic [7:0] anode_a;
    logic [7:0] seg_a;
    logic [7:0] anode_b;
    logic [7:0] seg_b;
    logic [1:0] slot;
    logic       ft;
    int         tag;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic [31:0] an_tab = {8'h7F, 8'hBF, 8'hDF, 8'hEF};

  task automatic chk(input string name, input int cyc, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
  endtask

  task automatic push_reset(input int tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.anode_a = 8'hFF; e.seg_a = 8'hFF; e.anode_b = 8'hFF; e.seg_b = 8'hFF;
      e.slot = 2'd3; e.ft = 1'b0; e.tag = tag; e.cyc = i;
      exp_q.push_back(e);
    end
  endtask

  // segs holds slot3..slot0 expected seg bytes; lit_lz marks slots lit with blanking on.
  task automatic push_frame(input int tag, input logic [31:0] segs, input logic [3:0] lit_lz,
                            input int ncyc, input int blk_lo, input int blk_hi);
    exp_t e;
    int k, ph;
    logic on;
    for (int c = 1; c <= ncyc; c++) begin
      k  = (c - 1) / SLOT;
      ph = (c - 1) % SLOT;
      on = (ph >= D) && !(blk_lo > 0 && c >= blk_lo && c <= blk_hi);
      e.slot    = (ph < D - 1) ? 2'(k + 3) : 2'(k);
      e.ft      = (ph == D - 1) && (k == 0);
      e.anode_a = (on && lit_lz[k]) ? an_tab[8*k +: 8] : 8'hFF;
      e.seg_a   = (on && lit_lz[k]) ? segs[8*k +: 8]   : 8'hFF;
      e.anode_b = on ? an_tab[8*k +: 8] : 8'hFF;
      e.seg_b   = on ? segs[8*k +: 8]   : 8'hFF;
      e.tag = tag; e.cyc = c;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: anode sanity every cycle, scoreboard pop whenever an expectation is pending.
  always begin
    exp_t e;
    @(posedge sysclock);
    #2;
    n_total++;
    if (anode_a[3:0] == 4'hF && anode_b[3:0] == 4'hF &&
        $countones(~anode_a) <= 1 && $countones(~anode_b) <= 1) n_pass++;
    else $display("FAIL anode_onehot t=%0t actual_a=%h actual_b=%h required=at most one low in [7:4]",
                  $time, anode_a, anode_b);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk($sformatf("scan_tag%0d", e.tag), e.cyc,
          64'({anode_a, seg_a, anode_b, seg_b, slot_a, slot_b, ft_a, ft_b}),
          64'({e.anode_a, e.seg_a, e.anode_b, e.seg_b, e.slot, e.slot, e.ft, e.ft}));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge sysclock);
  endtask

  initial begin
    push_reset(0, 3);
    cycles(3);
    reset = 1'b0;

    // Plain rotation, all digits lit.
    push_frame(1, 32'hF9A4B099, 4'hF, 4*SLOT, 0, 0);
    cycles(4*SLOT);

    // Leading zeros.
    digits = 16'h0007;
    push_frame(2, 32'hC0C0C0F8, 4'b0001, 4*SLOT, 0, 0);
    cycles(4*SLOT);
    digits = 16'h0000;
    push_frame(3, 32'hC0C0C0C0, 4'b0001, 4*SLOT, 0, 0);
    cycles(4*SLOT);

    // Dashes, embedded zero, decimal point.
    digits = 16'hA0F9; dp_in = 4'b0001;
    push_frame(4, 32'hBFC0BF10, 4'hF, 4*SLOT, 0, 0);
    cycles(4*SLOT);

    // Mid-slot digit change: slot 0 keeps its snapshot.
    digits = 16'h1234; dp_in = 4'b0000;
    push_frame(5, 32'h9282F899, 4'hF, 4*SLOT, 0, 0);
    cycles(5);
    digits = 16'h5678;
    cycles(4*SLOT - 5);

    // Blank for four cycles in the middle of slot 1.
    push_frame(6, 32'h9282F880, 4'hF, 4*SLOT, 15, 18);
    cycles(14);
    blank = 1'b1;
    cycles(4);
    blank = 1'b0;
    cycles(4*SLOT - 18);

    // Reset five lit cycles into slot 2.
    push_frame(7, 32'h9282F880, 4'hF, 2*SLOT + D + 5, 0, 0);
    cycles(2*SLOT + D + 5);
    reset = 1'b1;
    push_reset(8, 2);
    #1;
    chk("reset_async", 0, 64'({anode_a, seg_a, anode_b, seg_b, slot_a, slot_b, ft_a, ft_b}),
        64'({8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd3, 2'd3, 1'b0, 1'b0}));
    cycles(2);
    reset = 1'b0;
    push_frame(9, 32'h9282F880, 4'hF, 4*SLOT, 0, 0);
    cycles(4*SLOT);

    #3;
    chk("queue_drained", 0, 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
